// File: rtl/ref_clk_switch_ctrl.sv
// Break-before-make sequencer for the reference-clock divider tgate bank.
// Opens every gate for a dead time, closes the new one, then waits a settle time before acknowledging.
module ref_clk_switch_ctrl #(
    parameter int DEAD_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        DVDD,
    inout  wire        DVSS,
    input  logic       sel_req_valid,
    input  logic [2:0] sel_req,
    output logic       sel_req_ready,
    output logic [4:0] tgate_control,
    output logic [2:0] cur_sel,
    output logic       busy,
    output logic       switch_done,
    output logic       sel_err
);

    // state  | meaning
    // IDLE   | gates hold cur_sel, request accepted on valid && ready
    // BREAK  | all gates open for DEAD_CYCLES
    // MAKE   | target gate closed, settling for SETTLE_CYCLES
    // DONE   | one-cycle switch_done, back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_MAKE,
        ST_DONE
    } state_t;

    localparam logic [7:0] DEAD_LOAD   = 8'(DEAD_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [2:0] SEL_DEFAULT = 3'd1;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_target;

    logic       w_req_bad;
    logic [2:0] w_req_tgt;
    logic       w_unused_supply;

    assign w_req_bad       = (sel_req > 3'd4);
    assign w_req_tgt       = w_req_bad ? SEL_DEFAULT : sel_req;
    assign w_unused_supply = DVDD ^ DVSS;

    function automatic logic [4:0] f_onehot(input logic [2:0] s);
        return 5'(5'd1 << s);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_target      <= SEL_DEFAULT;
            tgate_control <= f_onehot(SEL_DEFAULT);
            cur_sel       <= SEL_DEFAULT;
            sel_req_ready <= 1'b1;
            busy          <= 1'b0;
            switch_done   <= 1'b0;
            sel_err       <= 1'b0;
        end else begin
            switch_done <= 1'b0;
            sel_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sel_req_valid) begin
                        r_target      <= w_req_tgt;
                        sel_err       <= w_req_bad;
                        sel_req_ready <= 1'b0;
                        busy          <= 1'b1;
                        if (w_req_tgt == cur_sel) begin
                            r_state     <= ST_DONE;
                            switch_done <= 1'b1;
                        end else begin
                            r_state       <= ST_BREAK;
                            tgate_control <= 5'b00000;
                            r_cnt         <= DEAD_LOAD;
                        end
                    end
                end
                ST_BREAK: begin
                    if (r_cnt == 8'd0) begin
                        r_state       <= ST_MAKE;
                        tgate_control <= f_onehot(r_target);
                        cur_sel       <= r_target;
                        r_cnt         <= SETTLE_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_MAKE: begin
                    if (r_cnt == 8'd0) begin
                        r_state     <= ST_DONE;
                        switch_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_DONE: begin
                    r_state       <= ST_IDLE;
                    sel_req_ready <= 1'b1;
                    busy          <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ref_clk_switch_ctrl.sv
// Bench for ref_clk_switch_ctrl: default-timing instance plus a DEAD=1/SETTLE=1 instance.
module tb_ref_clk_switch_ctrl;

    typedef struct {
        int         inst;
        logic [2:0] sel;
        logic [2:0] tgt;
        int         err;
        int         zeros;
        int         done_j;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    wire        dvdd;
    wire        dvss;
    assign dvdd = 1'b1;
    assign dvss = 1'b0;

    logic       valid [2];
    logic [2:0] req   [2];
    logic       rdy   [2];
    logic [4:0] tg    [2];
    logic [2:0] cs    [2];
    logic       bsy   [2];
    logic       sd    [2];
    logic       err   [2];

    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    vec_t exp_q [$];
    vec_t vecs  [9];

    always #5 clk = ~clk;

    ref_clk_switch_ctrl u_dut (
        .clk(clk), .rst(rst), .DVDD(dvdd), .DVSS(dvss),
        .sel_req_valid(valid[0]), .sel_req(req[0]), .sel_req_ready(rdy[0]),
        .tgate_control(tg[0]), .cur_sel(cs[0]), .busy(bsy[0]),
        .switch_done(sd[0]), .sel_err(err[0])
    );

    ref_clk_switch_ctrl #(.DEAD_CYCLES(1), .SETTLE_CYCLES(1)) u_fast (
        .clk(clk), .rst(rst), .DVDD(dvdd), .DVSS(dvss),
        .sel_req_valid(valid[1]), .sel_req(req[1]), .sel_req_ready(rdy[1]),
        .tgate_control(tg[1]), .cur_sel(cs[1]), .busy(bsy[1]),
        .switch_done(sd[1]), .sel_err(err[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Gate bank must never have two gates closed; busy mirrors !ready.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("onehot0_%0d", k), int'($onehot0(tg[k])), 1);
                chk($sformatf("busy_%0d", k), int'(bsy[k]), int'(!rdy[k]));
            end
        end
    end

    task automatic run_req(input vec_t v);
        int   k;
        int   j;
        int   zeros;
        int   rlow;
        int   errs;
        bit   done;
        vec_t e;
        k = v.inst;
        chk("ready_before", int'(rdy[k]), 1);
        valid[k] = 1'b1;
        req[k]   = v.sel;
        exp_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        valid[k] = 1'b0;
        req[k]   = 3'd0;
        j = 0; zeros = 0; rlow = 0; errs = 0; done = 1'b0;
        while (!done && j < 100) begin
            if (tg[k] == 5'd0) zeros++;
            if (!rdy[k]) rlow++;
            if (err[k]) errs++;
            if (sd[k]) done = 1'b1;
            else begin
                @(negedge clk);
                j++;
            end
        end
        chk("done_seen", int'(done), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("done_latency", j, e.done_j);
            chk("zero_gap", zeros, e.zeros);
            chk("ready_low", rlow, e.done_j + 1);
            chk("sel_err_pulses", errs, e.err);
            chk("cur_sel", int'(cs[k]), int'(e.tgt));
            chk("tgate", int'(tg[k]), int'(5'd1) << e.tgt);
        end
        @(negedge clk);
        chk("ready_after", int'(rdy[k]), 1);
        chk("done_after", int'(sd[k]), 0);
    endtask

    initial begin
        int   j;
        int   pulses;
        valid[0] = 1'b0; valid[1] = 1'b0;
        req[0]   = 3'd0; req[1]   = 3'd0;

        vecs[0] = '{0, 3'd4, 3'd4, 0, 4, 20};
        vecs[1] = '{0, 3'd4, 3'd4, 0, 0, 0};
        vecs[2] = '{0, 3'd0, 3'd0, 0, 4, 20};
        vecs[3] = '{0, 3'd6, 3'd1, 1, 4, 20};
        vecs[4] = '{0, 3'd1, 3'd1, 0, 0, 0};
        vecs[5] = '{0, 3'd7, 3'd1, 1, 0, 0};
        vecs[6] = '{1, 3'd0, 3'd0, 0, 1, 2};
        vecs[7] = '{1, 3'd2, 3'd2, 0, 1, 2};
        vecs[8] = '{1, 3'd0, 3'd0, 0, 1, 2};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("rst_tgate", int'(tg[k]), 2);
            chk("rst_cur_sel", int'(cs[k]), 1);
            chk("rst_ready", int'(rdy[k]), 1);
            chk("rst_busy", int'(bsy[k]), 0);
            chk("rst_done", int'(sd[k]), 0);
            chk("rst_err", int'(err[k]), 0);
        end
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) run_req(vecs[i]);

        // Request during BREAK is ignored, then reset lands in MAKE.
        valid[0] = 1'b1;
        req[0]   = 3'd3;
        @(posedge clk);
        @(negedge clk);
        req[0] = 3'd2;
        j = 0;
        while (tg[0] == 5'd0 && j < 50) begin
            @(negedge clk);
            j++;
        end
        valid[0] = 1'b0;
        chk("midop_make_seen", int'(j < 50), 1);
        chk("midop_tgate", int'(tg[0]), 8);
        chk("midop_cur_sel", int'(cs[0]), 3);
        chk("midop_ready", int'(rdy[0]), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_tgate", int'(tg[0]), 2);
        chk("midrst_cur_sel", int'(cs[0]), 1);
        chk("midrst_ready", int'(rdy[0]), 1);
        chk("midrst_busy", int'(bsy[0]), 0);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            if (sd[0]) pulses++;
            @(negedge clk);
        end
        chk("midrst_no_done", pulses, 0);
        chk("midrst_idle_tgate", int'(tg[0]), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ref_clk_switch_ctrl.md
# ref_clk_switch_ctrl

Sequencer for the reference-clock divider transmission-gate bank. Accepts a 3-bit divide-select request, opens all gates for a programmable dead time (break-before-make), closes the newly selected gate, then waits a settle time before acknowledging. Placed between the configuration registers and the tgate drivers, so the divided reference clock never sees two gates closed at once or a runt pulse.

## Interface
Parameters:
- DEAD_CYCLES, 4, cycles with all gates open between deselect and select; legal range 1..255
- SETTLE_CYCLES, 16, cycles the new gate is held before done is signalled; legal range 1..255

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- DVDD  inout  1  local digital supply
- DVSS  inout  1  local digital ground
- sel_req_valid  in  1  request strobe
- sel_req  in  3  requested select: 0..4 map to /512, /256, /128, /64, /32
- sel_req_ready  out  1  high only in IDLE; a request is accepted on an edge with valid && ready
- tgate_control  out  5  gate enables {32,64,128,256,512}, LSB = 512; one-hot or all-zero, never more than one bit set
- cur_sel  out  3  select currently applied to the gates
- busy  out  1  high in any state other than IDLE
- switch_done  out  1  one-cycle pulse when a request completes
- sel_err  out  1  one-cycle pulse, coincident with acceptance, when sel_req is 5..7

## Operation
- States: IDLE, BREAK, MAKE, DONE.
- Reset values, applied on the first edge with rst=1 from any state: state IDLE, tgate_control 5'b00010 (/256), cur_sel 3'd1, sel_req_ready 1, busy 0, switch_done 0, sel_err 0, counter 0.
- Invalid code: sel_req 5..7 is treated as 1 (/256). sel_err pulses and the request proceeds normally with target 1.
- IDLE: gates hold cur_sel one-hot. On acceptance, latch the target:
  - If target == cur_sel, go to DONE with no gate change.
  - Otherwise go to BREAK, set tgate_control to 0, and load the counter with DEAD_CYCLES-1.
- BREAK: tgate_control = 0. Decrement the counter. When the counter is 0, go to MAKE, set tgate_control to the target one-hot, set cur_sel to the target, and load the counter with SETTLE_CYCLES-1.
- MAKE: hold the target one-hot. Decrement the counter. When the counter is 0, go to DONE.
- DONE: switch_done = 1 for this cycle only. Next state is IDLE.
- sel_req_valid and sel_req are ignored while not in IDLE; requests are not queued.
- The counter is 8 bits and never wraps: it is loaded, then decremented to 0, and the state advances at 0.
- Reset mid-operation (BREAK or MAKE) abandons the request. Gates return to /256 on the next edge. No switch_done is issued.
- tgate_control changes only on the IDLE→BREAK and BREAK→MAKE transitions, and on reset. All outputs are registered.

## Timing
- Accept edge E0. tgate_control = 0 from after E0 through edge E0+DEAD_CYCLES, which is exactly DEAD_CYCLES cycles.
- New one-hot and cur_sel appear after E0+DEAD_CYCLES and are held for SETTLE_CYCLES cycles in MAKE.
- switch_done is high for the cycle after edge E0+DEAD_CYCLES+SETTLE_CYCLES.
- sel_req_ready is low for DEAD_CYCLES+SETTLE_CYCLES+1 cycles. With defaults: 21 cycles.
- Same-select request: switch_done is high the cycle after E0. sel_req_ready is low for 1 cycle and gates do not change.
- A request can be accepted on the first edge that sel_req_ready is high again. Back-to-back requests have no extra gap.
- busy equals !sel_req_ready.

## Test plan
- Reset: hold rst 2 cycles -> tgate_control=00010, cur_sel=1, ready=1, busy=0, no pulses.
- Switch 1→4 (defaults) -> tgate_control=00000 for exactly 4 cycles, then 10000 held, switch_done pulse 21 cycles after accept, ready low 21 cycles, never two bits set.
- Same select: request 1 while cur_sel=1 -> gates stay 00010, switch_done the next cycle, ready low 1 cycle.
- Invalid code 6 from cur_sel=0 -> sel_err pulses at accept, gates 00001→00000 (4 cycles)→00010, cur_sel=1, switch_done issued.
- Request ignored and reset mid-op: assert valid with sel 3 during BREAK -> ignored. Then assert rst during MAKE -> next cycle tgate_control=00010, cur_sel=1, ready=1, no switch_done.
- Back-to-back and parameter corners: DEAD=1, SETTLE=1, requests 0→2→0 issued on each ready edge -> each zero gap is 1 cycle, each switch takes 3 cycles. Scoreboard checks one-hot/zero invariant on every cycle.
